// File: rtl/mdu_sequencer_if.sv
// Signal bundle between the EX stage, the mdu_sequencer and the multi-cycle mdu.
interface mdu_sequencer_if #(
    parameter int CNT_W = 32
);
    logic             req_valid;
    logic [2:0]       req_funct3;
    logic [31:0]      req_a;
    logic [31:0]      req_b;
    logic [4:0]       req_rd;
    logic             flush;
    logic             stall;
    logic             resp_valid;
    logic [31:0]      resp_data;
    logic [4:0]       resp_rd;
    logic             mdu_start;
    logic [2:0]       mdu_funct3;
    logic [31:0]      mdu_a;
    logic [31:0]      mdu_b;
    logic [31:0]      mdu_f;
    logic             mdu_done;
    logic [CNT_W-1:0] cnt_ops;
    logic [CNT_W-1:0] cnt_busy;

    // master is the sequencer; slave is the pipeline plus mdu around it
    modport master (
        input  req_valid, req_funct3, req_a, req_b, req_rd, flush, mdu_f, mdu_done,
        output stall, resp_valid, resp_data, resp_rd, mdu_start, mdu_funct3, mdu_a, mdu_b,
               cnt_ops, cnt_busy
    );

    modport slave (
        output req_valid, req_funct3, req_a, req_b, req_rd, flush, mdu_f, mdu_done,
        input  stall, resp_valid, resp_data, resp_rd, mdu_start, mdu_funct3, mdu_a, mdu_b,
               cnt_ops, cnt_busy
    );
endinterface

// File: rtl/mdu_sequencer.sv
// Issue/sequencing controller between EX and the multi-cycle RV32M mdu: resolves the
// div-by-zero/overflow corner cases locally, replays the last mdu result and pulses one response.
module mdu_sequencer #(
    parameter bit CACHE_EN = 1'b1,
    parameter int CNT_W    = 32
) (
    input  logic            clk,
    input  logic            rst,
    mdu_sequencer_if.master seq_if
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP, ABORT} state_e;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [31:0]      a_q, a_d, b_q, b_d;
    logic [4:0]       rd_q, rd_d;
    logic [31:0]      res_q, res_d;
    logic             start_q, start_d;
    logic             cache_valid_q, cache_valid_d;
    logic [66:0]      cache_key_q, cache_key_d;
    logic [31:0]      cache_data_q, cache_data_d;
    logic [CNT_W-1:0] ops_q, ops_d, busy_q, busy_d;

    logic        accept, b_zero, ovf, special, hit;
    logic [31:0] special_res;
    logic [66:0] req_key;

    assign req_key = {seq_if.req_funct3, seq_if.req_a, seq_if.req_b};
    assign accept  = (state_q == IDLE) && seq_if.req_valid && !seq_if.flush;
    assign b_zero  = (seq_if.req_b == 32'd0);
    // only the signed div (100) and rem (110) encodings can overflow
    assign ovf     = (seq_if.req_funct3[2:0] == 3'b100 || seq_if.req_funct3[2:0] == 3'b110)
                     && (seq_if.req_a == 32'h8000_0000) && (seq_if.req_b == 32'hFFFF_FFFF);
    assign special = seq_if.req_funct3[2] && (b_zero || ovf);
    assign hit     = CACHE_EN && cache_valid_q && (req_key == cache_key_q);

    always_comb begin
        special_res = 32'd0;
        if (b_zero) begin
            special_res = seq_if.req_funct3[1] ? seq_if.req_a : 32'hFFFF_FFFF;
        end else if (!seq_if.req_funct3[1]) begin
            special_res = 32'h8000_0000;
        end
    end

    always_comb begin
        state_d       = state_q;
        funct3_d      = funct3_q;
        a_d           = a_q;
        b_d           = b_q;
        rd_d          = rd_q;
        res_d         = res_q;
        start_d       = 1'b0;
        cache_valid_d = cache_valid_q;
        cache_key_d   = cache_key_q;
        cache_data_d  = cache_data_q;
        ops_d         = ops_q;
        busy_d        = busy_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    funct3_d = seq_if.req_funct3;
                    a_d      = seq_if.req_a;
                    b_d      = seq_if.req_b;
                    rd_d     = seq_if.req_rd;
                    ops_d    = (ops_q == CNT_MAX) ? ops_q : ops_q + CNT_ONE;
                    if (special) begin
                        res_d   = special_res;
                        state_d = RESP;
                    end else if (hit) begin
                        res_d   = cache_data_q;
                        state_d = RESP;
                    end else begin
                        start_d = 1'b1;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                busy_d  = (busy_q == CNT_MAX) ? busy_q : busy_q + CNT_ONE;
                start_d = 1'b1;
                // a flush wins even over a simultaneous done; that result is dropped
                if (seq_if.flush) begin
                    start_d = 1'b0;
                    state_d = ABORT;
                end else if (seq_if.mdu_done) begin
                    start_d       = 1'b0;
                    res_d         = seq_if.mdu_f;
                    cache_valid_d = 1'b1;
                    cache_key_d   = {funct3_q, a_q, b_q};
                    cache_data_d  = seq_if.mdu_f;
                    state_d       = RESP;
                end
            end
            RESP:    state_d = IDLE;
            ABORT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            funct3_q      <= 3'd0;
            a_q           <= 32'd0;
            b_q           <= 32'd0;
            rd_q          <= 5'd0;
            res_q         <= 32'd0;
            start_q       <= 1'b0;
            cache_valid_q <= 1'b0;
            cache_key_q   <= 67'd0;
            cache_data_q  <= 32'd0;
            ops_q         <= '0;
            busy_q        <= '0;
        end else begin
            state_q       <= state_d;
            funct3_q      <= funct3_d;
            a_q           <= a_d;
            b_q           <= b_d;
            rd_q          <= rd_d;
            res_q         <= res_d;
            start_q       <= start_d;
            cache_valid_q <= cache_valid_d;
            cache_key_q   <= cache_key_d;
            cache_data_q  <= cache_data_d;
            ops_q         <= ops_d;
            busy_q        <= busy_d;
        end
    end

    assign seq_if.stall      = seq_if.req_valid && (state_q != RESP) && !seq_if.flush;
    assign seq_if.resp_valid = (state_q == RESP) && !seq_if.flush;
    assign seq_if.resp_data  = res_q;
    assign seq_if.resp_rd    = rd_q;
    assign seq_if.mdu_start  = start_q;
    assign seq_if.mdu_funct3 = funct3_q;
    assign seq_if.mdu_a      = a_q;
    assign seq_if.mdu_b      = b_q;
    assign seq_if.cnt_ops    = ops_q;
    assign seq_if.cnt_busy   = busy_q;
endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: behavioural mdu responders plus an RV32M/cache reference model.
module tb_mdu_sequencer;
    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    mdu_sequencer_if #(.CNT_W(32)) bus ();
    mdu_sequencer_if #(.CNT_W(3))  bus1 ();

    mdu_sequencer #(.CACHE_EN(1'b1), .CNT_W(32)) dut   (.clk(clk), .rst(rst), .seq_if(bus));
    mdu_sequencer #(.CACHE_EN(1'b0), .CNT_W(3))  dutNc (.clk(clk), .rst(rst), .seq_if(bus1));

    int vectors = 0;
    int miscompares = 0;
    int mduLat = 4, mduLat1 = 2;
    int mduCnt, mduCnt1;
    int expOps = 0, expBusy = 0;
    bit cacheValid = 0;
    logic [2:0]  cacheF;
    logic [31:0] cacheA, cacheB;

    // RV32M semantics straight from the ISA rules, including the two corner cases
    function automatic logic [31:0] refMdu(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, p;
        logic [63:0] ua, ub, pu;
        int qa, qb;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        qa = a;
        qb = b;
        case (f)
            3'd0: begin pu = ua * ub; return pu[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * $signed(ub); return p[63:32]; end
            3'd3: begin pu = ua * ub; return pu[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return qa / qb;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return qa % qb;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit isSpecial(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        bit divLike, signedDivLike;
        divLike       = (f == 3'd4) || (f == 3'd5) || (f == 3'd6) || (f == 3'd7);
        signedDivLike = (f == 3'd4) || (f == 3'd6);
        return (divLike && b == 0) || (signedDivLike && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(1, 9));
            default: return $urandom;
        endcase
    endfunction

    always @(negedge clk) begin
        if (rst || !bus.mdu_start) begin
            mduCnt = 0;
            bus.mdu_done = 1'b0;
            bus.mdu_f = 32'd0;
        end else begin
            mduCnt++;
            bus.mdu_done = (mduCnt == mduLat);
            bus.mdu_f = (mduCnt == mduLat) ? refMdu(bus.mdu_funct3, bus.mdu_a, bus.mdu_b) : 32'hDEAD_BEEF;
        end
    end

    always @(negedge clk) begin
        if (rst || !bus1.mdu_start) begin
            mduCnt1 = 0;
            bus1.mdu_done = 1'b0;
            bus1.mdu_f = 32'd0;
        end else begin
            mduCnt1++;
            bus1.mdu_done = (mduCnt1 == mduLat1);
            bus1.mdu_f = (mduCnt1 == mduLat1) ? refMdu(bus1.mdu_funct3, bus1.mdu_a, bus1.mdu_b) : 32'hDEAD_BEEF;
        end
    end

    // Presents one op from a negedge until its response, then watches two more cycles.
    task automatic runOp(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                         output int lat, output logic [31:0] data, output logic [4:0] rdo,
                         output bit sawStart, output bit stallBad, output bit opBad,
                         output int pulses, output bit afterBad);
        int respK;
        lat = -1; data = '0; rdo = '0; sawStart = 0; stallBad = 0; opBad = 0;
        pulses = 0; afterBad = 0; respK = -1;
        bus.req_funct3 = f; bus.req_a = a; bus.req_b = b; bus.req_rd = rd; bus.req_valid = 1'b1;
        for (int k = 0; k < 80; k++) begin
            #1;
            if (respK < 0) begin
                if (bus.mdu_start) begin
                    sawStart = 1;
                    if (bus.mdu_funct3 !== f || bus.mdu_a !== a || bus.mdu_b !== b) opBad = 1;
                end
                if (bus.resp_valid) begin
                    respK = k; lat = k; data = bus.resp_data; rdo = bus.resp_rd; pulses = 1;
                    if (bus.stall !== 1'b0) stallBad = 1;
                end else if (bus.stall !== 1'b1) begin
                    stallBad = 1;
                end
            end else begin
                if (bus.resp_valid) pulses++;
                if (bus.mdu_start) afterBad = 1;
            end
            @(negedge clk);
            if (respK >= 0) bus.req_valid = 1'b0;
            if (respK >= 0 && k >= respK + 2) break;
        end
        bus.req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if ({bus.stall, bus.resp_valid, bus.resp_data, bus.resp_rd, bus.mdu_start, bus.mdu_funct3,
             bus.mdu_a, bus.mdu_b, bus.cnt_ops, bus.cnt_busy} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs got start=%b resp=%b data=%h cnt_ops=%0d exp all zero",
                     bus.mdu_start, bus.resp_valid, bus.resp_data, bus.cnt_ops);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++;
        if ({bus.mdu_start, bus.resp_valid, bus.cnt_ops, bus.cnt_busy} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_release got start=%b resp=%b ops=%0d busy=%0d exp 0",
                     bus.mdu_start, bus.resp_valid, bus.cnt_ops, bus.cnt_busy);
        end
        @(negedge clk);
    endtask

    task automatic test_mul_basic();
        int lat, pulses; logic [31:0] data; logic [4:0] rdo; bit st, sb, ob, ab;
        mduLat = 4;
        runOp(3'd0, 32'd3, 32'd7, 5'd5, lat, data, rdo, st, sb, ob, pulses, ab);
        expOps++; expBusy += 4;
        cacheValid = 1; cacheF = 3'd0; cacheA = 32'd3; cacheB = 32'd7;
        vectors++;
        if (data !== 32'd21 || rdo !== 5'd5) begin
            miscompares++;
            $display("[TB] FAIL mul_data got %h rd %0d exp 00000015 rd 5", data, rdo);
        end
        vectors++;
        if (lat !== 5) begin
            miscompares++;
            $display("[TB] FAIL mul_latency got %0d exp 5", lat);
        end
        vectors++;
        if (st !== 1'b1 || sb || ob || pulses !== 1 || ab) begin
            miscompares++;
            $display("[TB] FAIL mul_protocol got start=%b stallBad=%b opBad=%b pulses=%0d after=%b exp 1 0 0 1 0",
                     st, sb, ob, pulses, ab);
        end
    endtask

    task automatic test_special();
        logic [2:0]  fs [6] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6};
        logic [31:0] as [6] = '{32'd5, 32'd5, 32'hCAFE_0001, 32'hCAFE_0002, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs [6] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        int lat, pulses; logic [31:0] data; logic [4:0] rdo; bit st, sb, ob, ab;
        for (int i = 0; i < 6; i++) begin
            runOp(fs[i], as[i], bs[i], 5'(i + 1), lat, data, rdo, st, sb, ob, pulses, ab);
            expOps++;
            vectors++;
            if (data !== refMdu(fs[i], as[i], bs[i]) || lat !== 1 || st !== 1'b0 || pulses !== 1) begin
                miscompares++;
                $display("[TB] FAIL special_%0d got data=%h lat=%0d start=%b pulses=%0d exp data=%h lat=1 start=0",
                         i, data, lat, st, pulses, refMdu(fs[i], as[i], bs[i]));
            end
        end
    endtask

    task automatic test_cache();
        int lat, pulses; logic [31:0] data; logic [4:0] rdo; bit st, sb, ob, ab;
        mduLat = 3;
        runOp(3'd3, 32'hFFFF_FFFF, 32'd2, 5'd10, lat, data, rdo, st, sb, ob, pulses, ab);
        expOps++; expBusy += 3;
        vectors++;
        if (data !== 32'd1 || lat !== 4 || st !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL cache_fill got data=%h lat=%0d start=%b exp 00000001 4 1", data, lat, st);
        end
        runOp(3'd3, 32'hFFFF_FFFF, 32'd2, 5'd11, lat, data, rdo, st, sb, ob, pulses, ab);
        expOps++;
        vectors++;
        if (data !== 32'd1 || lat !== 1 || st !== 1'b0 || rdo !== 5'd11) begin
            miscompares++;
            $display("[TB] FAIL cache_hit got data=%h lat=%0d start=%b rd=%0d exp 00000001 1 0 11", data, lat, st, rdo);
        end
        runOp(3'd3, 32'hFFFF_FFFF, 32'd3, 5'd12, lat, data, rdo, st, sb, ob, pulses, ab);
        expOps++; expBusy += 3;
        cacheValid = 1; cacheF = 3'd3; cacheA = 32'hFFFF_FFFF; cacheB = 32'd3;
        vectors++;
        if (data !== 32'd2 || lat !== 4 || st !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL cache_miss got data=%h lat=%0d start=%b exp 00000002 4 1", data, lat, st);
        end
    endtask

    task automatic test_nocache();
        int seen, expO, expB; logic [31:0] got;
        mduLat1 = 2;
        for (int i = 1; i <= 9; i++) begin
            bus1.req_funct3 = 3'd3; bus1.req_a = 32'hFFFF_FFFF; bus1.req_b = 32'd2;
            bus1.req_rd = 5'(i); bus1.req_valid = 1'b1;
            seen = -1; got = '0;
            for (int k = 0; k < 20 && seen < 0; k++) begin
                #1;
                if (bus1.resp_valid) begin seen = k; got = bus1.resp_data; end
                @(negedge clk);
            end
            bus1.req_valid = 1'b0;
            @(negedge clk);
            #1;
            expO = (i > 7) ? 7 : i;
            expB = (2 * i > 7) ? 7 : 2 * i;
            vectors++;
            if (seen !== 3 || got !== 32'd1) begin
                miscompares++;
                $display("[TB] FAIL nocache_op%0d got lat=%0d data=%h exp lat=3 data=00000001", i, seen, got);
            end
            vectors++;
            if (int'(bus1.cnt_ops) !== expO || int'(bus1.cnt_busy) !== expB) begin
                miscompares++;
                $display("[TB] FAIL sat_counters_op%0d got ops=%0d busy=%0d exp ops=%0d busy=%0d",
                         i, bus1.cnt_ops, bus1.cnt_busy, expO, expB);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        logic [2:0] f; logic [31:0] a, b, expData, data; logic [4:0] rd, rdo;
        int lat, expLat, pulses; bit st, sb, ob, ab, fast, hitNow;
        for (int n = 0; n < 40; n++) begin
            if (cacheValid && $urandom_range(0, 3) == 0) begin
                f = cacheF; a = cacheA; b = cacheB;
            end else begin
                f = 3'($urandom_range(0, 7)); a = pickOperand(); b = pickOperand();
            end
            rd = 5'($urandom_range(0, 31));
            mduLat = int'($urandom_range(1, 6));
            hitNow = cacheValid && f == cacheF && a == cacheA && b == cacheB;
            fast = isSpecial(f, a, b) || hitNow;
            expLat = fast ? 1 : mduLat + 1;
            expData = refMdu(f, a, b);
            runOp(f, a, b, rd, lat, data, rdo, st, sb, ob, pulses, ab);
            expOps++;
            if (!fast) begin
                expBusy += mduLat;
                cacheValid = 1; cacheF = f; cacheA = a; cacheB = b;
            end
            vectors++;
            if (data !== expData || rdo !== rd || lat !== expLat) begin
                miscompares++;
                $display("[TB] FAIL random_%0d f=%0d a=%h b=%h got data=%h rd=%0d lat=%0d exp data=%h rd=%0d lat=%0d",
                         n, f, a, b, data, rdo, lat, expData, rd, expLat);
            end
            vectors++;
            if (st !== !fast || sb || ob || pulses !== 1 || ab) begin
                miscompares++;
                $display("[TB] FAIL random_proto_%0d got start=%b stallBad=%b opBad=%b pulses=%0d after=%b exp start=%b",
                         n, st, sb, ob, pulses, ab, !fast);
            end
        end
    endtask

    task automatic test_counters();
        #1;
        vectors++;
        if (int'(bus.cnt_ops) !== expOps || int'(bus.cnt_busy) !== expBusy) begin
            miscompares++;
            $display("[TB] FAIL counters got ops=%0d busy=%0d exp ops=%0d busy=%0d",
                     bus.cnt_ops, bus.cnt_busy, expOps, expBusy);
        end
        @(negedge clk);
    endtask

    task automatic test_flush();
        int lat, pulses; logic [31:0] data; logic [4:0] rdo; bit st, sb, ob, ab;
        bus.req_funct3 = 3'd0; bus.req_a = 32'd5; bus.req_b = 32'd9; bus.req_rd = 5'd3;
        bus.req_valid = 1'b1; bus.flush = 1'b1;
        #1;
        vectors++;
        if (bus.stall !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL flush_idle_stall got %b exp 0", bus.stall);
        end
        @(negedge clk);
        bus.req_valid = 1'b0; bus.flush = 1'b0;
        #1;
        vectors++;
        if (bus.mdu_start !== 1'b0 || bus.resp_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL flush_idle_accept got start=%b resp=%b exp 0 0", bus.mdu_start, bus.resp_valid);
        end
        @(negedge clk);
        mduLat = 2;
        bus.req_funct3 = 3'd1; bus.req_a = 32'h1234_5678; bus.req_b = 32'h0ABC_DEF1; bus.req_rd = 5'd9;
        bus.req_valid = 1'b1;
        repeat (2) @(negedge clk);
        bus.flush = 1'b1;
        #1;
        vectors++;
        if (bus.resp_valid !== 1'b0 || bus.stall !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL flush_busy_cycle got resp=%b stall=%b exp 0 0", bus.resp_valid, bus.stall);
        end
        @(negedge clk);
        bus.flush = 1'b0;
        #1;
        vectors++;
        if (bus.mdu_start !== 1'b0 || bus.resp_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL flush_abort got start=%b resp=%b exp 0 0", bus.mdu_start, bus.resp_valid);
        end
        runOp(3'd1, 32'h1234_5678, 32'h0ABC_DEF1, 5'd9, lat, data, rdo, st, sb, ob, pulses, ab);
        expOps += 2; expBusy += 4;
        cacheValid = 1; cacheF = 3'd1; cacheA = 32'h1234_5678; cacheB = 32'h0ABC_DEF1;
        vectors++;
        if (lat !== 4 || st !== 1'b1 || data !== refMdu(3'd1, 32'h1234_5678, 32'h0ABC_DEF1) || pulses !== 1) begin
            miscompares++;
            $display("[TB] FAIL flush_reissue got lat=%0d start=%b data=%h pulses=%0d exp lat=4 start=1 data=%h",
                     lat, st, data, pulses, refMdu(3'd1, 32'h1234_5678, 32'h0ABC_DEF1));
        end
        test_counters();
    endtask

    task automatic test_reset_mid_busy();
        int lat, pulses; logic [31:0] data; logic [4:0] rdo; bit st, sb, ob, ab;
        mduLat = 20;
        bus.req_funct3 = 3'd0; bus.req_a = 32'h0000_1111; bus.req_b = 32'h0000_2222; bus.req_rd = 5'd7;
        bus.req_valid = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1; bus.req_valid = 1'b0;
        #1;
        vectors++;
        if ({bus.stall, bus.resp_valid, bus.resp_data, bus.resp_rd, bus.mdu_start, bus.mdu_funct3,
             bus.mdu_a, bus.mdu_b, bus.cnt_ops, bus.cnt_busy} !== '0) begin
            miscompares++;
            $display("[TB] FAIL async_reset got start=%b a=%h data=%h rd=%0d ops=%0d busy=%0d exp all zero",
                     bus.mdu_start, bus.mdu_a, bus.resp_data, bus.resp_rd, bus.cnt_ops, bus.cnt_busy);
        end
        @(negedge clk);
        rst = 1'b0;
        expOps = 0; expBusy = 0; cacheValid = 0;
        @(negedge clk);
        mduLat = 3;
        runOp(3'd1, 32'h1234_5678, 32'h0ABC_DEF1, 5'd4, lat, data, rdo, st, sb, ob, pulses, ab);
        expOps++; expBusy += 3;
        vectors++;
        if (lat !== 4 || st !== 1'b1 || data !== refMdu(3'd1, 32'h1234_5678, 32'h0ABC_DEF1) || rdo !== 5'd4) begin
            miscompares++;
            $display("[TB] FAIL post_reset_op got lat=%0d start=%b data=%h rd=%0d exp lat=4 start=1 data=%h rd=4",
                     lat, st, data, rdo, refMdu(3'd1, 32'h1234_5678, 32'h0ABC_DEF1));
        end
        test_counters();
    endtask

    initial begin
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_funct3 = '0; bus.req_a = '0; bus.req_b = '0; bus.req_rd = '0; bus.flush = 1'b0;
        bus1.req_valid = 1'b0; bus1.req_funct3 = '0; bus1.req_a = '0; bus1.req_b = '0; bus1.req_rd = '0; bus1.flush = 1'b0;
        test_reset();
        test_mul_basic();
        test_special();
        test_cache();
        test_nocache();
        test_random();
        test_counters();
        test_flush();
        test_reset_mid_busy();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
